// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults: address width, register count,
// hardwired-zero index and the per-register one-hot select type.
package regfile_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
    localparam int RF_ZERO_REG = RF_NUM_REGS - 1;

    typedef logic [RF_NUM_REGS-1:0] reg_onehot_t;

endpackage

// File: rtl/decoder_n.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
module decoder_n
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_decode.sv
// Multi-port registered write-select decoder with fixed-priority arbitration.
// Latency: 1 cycle for wr_sel/wr_sel_any/conflict, 2 cycles for conflict_cnt.
// Backpressure: stall discards the current requests; nothing is held.
module regfile_wr_decode
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int NUM_PORTS = 2,
    parameter int ZERO_REG  = (2 ** ADDR_W) - 1,
    parameter int CNT_W     = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_PORTS-1:0]              wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]       wr_addr,
    input  logic                              stall,
    output logic [NUM_PORTS*(2**ADDR_W)-1:0]  wr_sel,
    output logic [2**ADDR_W-1:0]              wr_sel_any,
    output logic                              conflict,
    output logic [CNT_W-1:0]                  conflict_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]           cand [NUM_PORTS];
    logic [NUM_REGS-1:0]           claimed;
    logic [NUM_PORTS*NUM_REGS-1:0] sel_d, sel_q;
    logic [NUM_REGS-1:0]           any_d, any_q;
    logic                          conflict_d, conflict_q;
    logic [CNT_W-1:0]              cnt_d, cnt_q;

    // Zero-register and stalled requests never reach arbitration, so they
    // can neither win a slot nor be counted as a conflict.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        decoder_n #(
            .ADDR_W (ADDR_W)
        ) u_dec (
            .en     (wr_en[p] && !stall && (wr_addr[p*ADDR_W +: ADDR_W] != ZERO_ADDR)),
            .addr   (wr_addr[p*ADDR_W +: ADDR_W]),
            .onehot (cand[p])
        );
    end

    always_comb begin
        claimed    = '0;
        sel_d      = '0;
        any_d      = '0;
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if ((cand[p] & claimed) != '0) begin
                conflict_d = 1'b1;
            end else begin
                sel_d[p*NUM_REGS +: NUM_REGS] = cand[p];
                any_d                         = any_d | cand[p];
            end
            claimed = claimed | cand[p];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (conflict_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q      <= '0;
            any_q      <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sel_q      <= sel_d;
            any_q      <= any_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wr_sel       = sel_q;
    assign wr_sel_any   = any_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_decode.sv
// Scoreboard bench for regfile_wr_decode: driver pushes model results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_wr_decode;
    import regfile_pkg::*;

    localparam int NP = 2;
    localparam int AW = RF_ADDR_W;
    localparam int NR = RF_NUM_REGS;
    localparam int CW = 8;
    localparam int CNT_SAT = (2 ** CW) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     wr_en;
    logic [NP*AW-1:0]  wr_addr;
    logic              stall;
    logic [NP*NR-1:0]  wr_sel;
    reg_onehot_t       wr_sel_any;
    logic              conflict;
    logic [CW-1:0]     conflict_cnt;

    typedef struct {
        logic [NP*NR-1:0] sel;
        reg_onehot_t      any;
        logic             conf;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_cnt = 0;

    regfile_wr_decode #(
        .ADDR_W    (AW),
        .NUM_PORTS (NP),
        .ZERO_REG  (RF_ZERO_REG),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .stall        (stall),
        .wr_sel       (wr_sel),
        .wr_sel_any   (wr_sel_any),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one request set, wait for the capturing edge, then push the
    // result the model predicts for that edge.
    task automatic cycle(input logic [NP-1:0] en, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic st, input logic rn);
        exp_t e;
        bit   taken [NR];
        int   addrs [NP];
        wr_en   = en;
        wr_addr = {a1, a0};
        stall   = st;
        reset_n = rn;
        @(posedge clk);
        addrs[0] = int'(a0);
        addrs[1] = int'(a1);
        foreach (taken[i]) taken[i] = 1'b0;
        e.sel  = '0;
        e.any  = '0;
        e.conf = 1'b0;
        e.cnt  = CW'(model_cnt);
        if (!rn) begin
            e.cnt     = '0;
            model_cnt = 0;
        end else if (!st) begin
            for (int p = 0; p < NP; p++) begin
                if (en[p] && addrs[p] != RF_ZERO_REG) begin
                    if (taken[addrs[p]]) begin
                        e.conf = 1'b1;
                    end else begin
                        taken[addrs[p]]       = 1'b1;
                        e.sel[p*NR + addrs[p]] = 1'b1;
                        e.any[addrs[p]]        = 1'b1;
                    end
                end
            end
        end
        if (rn && e.conf && model_cnt < CNT_SAT) model_cnt++;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: one DUT result per clock once the scoreboard holds one.
    initial begin
        exp_t        e;
        reg_onehot_t r0, r1;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                r0 = wr_sel[0 +: NR];
                r1 = wr_sel[NR +: NR];
                check("wr_sel",       wr_sel,       e.sel);
                check("wr_sel_any",   wr_sel_any,   e.any);
                check("conflict",     conflict,     e.conf);
                check("conflict_cnt", conflict_cnt, e.cnt);
                check("row_at_most_onehot", ($countones(r0) <= 1) && ($countones(r1) <= 1), 1'b1);
                check("rows_disjoint", r0 & r1, '0);
                check("zero_reg_bit", {r0[RF_ZERO_REG], r1[RF_ZERO_REG], wr_sel_any[RF_ZERO_REG]}, 3'b000);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        // reset and idle
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle(2'b11, 5'd4, 5'd6, 1'b0, 1'b0);
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
        // single port, then idle
        cycle(2'b01, 5'd5, 5'd0, 1'b0, 1'b1);
        cycle(2'b00, 5'd5, 5'd0, 1'b0, 1'b1);
        // zero register on one and both ports
        cycle(2'b01, 5'd31, 5'd0, 1'b0, 1'b1);
        cycle(2'b11, 5'd31, 5'd31, 1'b0, 1'b1);
        // conflict, then idle so the count can be seen
        cycle(2'b11, 5'd7, 5'd7, 1'b0, 1'b1);
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
        // distinct addresses
        cycle(2'b11, 5'd3, 5'd9, 1'b0, 1'b1);
        // stall beats conflict, then re-present
        cycle(2'b11, 5'd7, 5'd7, 1'b1, 1'b1);
        cycle(2'b11, 5'd7, 5'd7, 1'b0, 1'b1);
        // back-to-back identical requests
        cycle(2'b10, 5'd12, 5'd12, 1'b0, 1'b1);
        cycle(2'b10, 5'd12, 5'd12, 1'b0, 1'b1);
        // saturation: 260 conflict cycles
        for (int i = 0; i < 260; i++) begin
            a = AW'($urandom_range(0, NR - 2));
            cycle(2'b11, a, a, 1'b0, 1'b1);
        end
        cycle(2'b11, 5'd2, 5'd2, 1'b0, 1'b1);
        // reset with a request on the same edge
        cycle(2'b11, 5'd8, 5'd8, 1'b0, 1'b0);
        cycle(2'b01, 5'd1, 5'd0, 1'b0, 1'b1);
        // sweep every address on every port with every enable pattern
        for (int ai = 0; ai < NR; ai++) begin
            for (int en = 0; en < 4; en++) begin
                cycle(2'(en), AW'(ai), AW'(NR - 1 - ai), 1'b0, 1'b1);
                cycle(2'(en), AW'(ai), AW'(ai), 1'b0, 1'b1);
            end
        end
        // random traffic biased toward collisions and the zero register
        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0] r0, r1;
            r0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(24, 31));
            r1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(24, 31));
            cycle(2'($urandom_range(0, 3)), r0, r1,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
        end
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_decode.md
# regfile_wr_decode

Parametrised, registered write-port address decoder for the register file. Turns NUM_PORTS independent (enable, address) write requests into one-hot per-register write-select vectors, one clock after the request. It suppresses writes to the hardwired zero register and resolves same-address conflicts between ports by fixed priority. It sits between the writeback stage and the register array's per-register enables, replacing the single-port combinational 3:8 decode with a pipelined, multi-port, arbitrated stage.

## Interface
Parameters:
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- NUM_PORTS, 2, independent write ports (1..4)
- ZERO_REG, NUM_REGS-1, index of the hardwired-zero register; writes to it are dropped
- CNT_W, 8, width of the saturating conflict counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  NUM_PORTS  per-port write request
- wr_addr  in  NUM_PORTS x ADDR_W  per-port target register
- stall  in  1  pipeline freeze; requests this cycle are discarded
- wr_sel  out  NUM_PORTS x NUM_REGS  registered one-hot (or zero) select per port
- wr_sel_any  out  NUM_REGS  OR of all wr_sel rows
- conflict  out  1  one-cycle pulse: a lower-priority port lost arbitration
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- Each cycle, per port p, form a candidate one-hot vector:
  - decode(wr_addr[p]) if wr_en[p] and wr_addr[p] != ZERO_REG
  - all-zero otherwise
- Arbitration is fixed priority, lower port index wins. Port p's candidate is cleared if any port q<p has a valid candidate to the same address.
- conflict is computed as the OR over ports of "candidate cleared by arbitration".
- A zero-register request never counts as a conflict.
- Multiple losers in one cycle produce a single conflict pulse and a single count increment.
- stall=1: all candidates are forced to zero and conflict is forced to 0 for that cycle. No request is held; upstream re-presents it.
- conflict_cnt increments by 1 on each cycle whose registered conflict is 1, and saturates at 2**CNT_W-1. It is cleared only by reset.
- wr_sel_any is registered alongside wr_sel, in the same cycle, with no extra latency.
- Invariants:
  - each wr_sel row is at most one-hot;
  - wr_sel rows are pairwise disjoint;
  - bit ZERO_REG of every output is always 0.

## Timing
- Latency: request sampled at edge N appears on wr_sel/wr_sel_any/conflict from edge N+1, valid for exactly one cycle. Throughput: one request set per port per cycle.
- conflict_cnt reflects a conflict one cycle after the conflict pulse, i.e. edge N+2 relative to the request.
- Reset, when reset_n=0 at an edge:
  - wr_sel = 0, wr_sel_any = 0, conflict = 0, conflict_cnt = 0 from that edge.
  - Requests presented during reset are discarded.
- Reset mid-operation: a request sampled on the same edge reset is asserted never appears. The first request honoured is the one sampled at the first edge with reset_n=1.
- Simultaneous stall and conflict: stall wins; no pulse, no count.
- Counter at saturation plus conflict: the counter holds, the pulse still asserts.
- Back-to-back identical requests produce back-to-back identical selects. No deduplication across cycles.

## Structure
- Shared package regfile_pkg holds:
  - default ADDR_W;
  - localparam NUM_REGS;
  - default ZERO_REG;
  - typedef logic [NUM_REGS-1:0] reg_onehot_t, shared with the register array and read muxes.
- Sub-module decoder_n: combinational ADDR_W-to-NUM_REGS decoder with enable, instantiated once per port via generate. Arbitration, output registers and counter live in the top.

## Test plan
- Single port, reset released: wr_en[0]=1, wr_addr[0]=5 at edge N -> wr_sel[0]=32'h0000_0020, wr_sel_any identical at edge N+1, all zero at N+2.
- Zero register: wr_en[0]=1, wr_addr[0]=31 -> wr_sel all zero, conflict=0, conflict_cnt unchanged.
- Conflict: ports 0 and 1 both write addr 7 -> wr_sel[0]=bit 7, wr_sel[1]=0, conflict=1 for one cycle, conflict_cnt=1 one cycle later. Distinct addresses 3 and 9 -> both rows set, no conflict.
- Stall: same conflicting request with stall=1 -> all outputs zero, count unchanged. Release stall and re-present -> normal selects at the following edge.
- Saturation: 260 consecutive conflict cycles with CNT_W=8 -> conflict_cnt stops at 255 and conflict keeps pulsing. Then reset_n=0 for one edge -> all outputs 0, including a request presented on that edge.
- Sweep: every address 0..31 on every port, both enable values -> each row exactly one-hot at the decoded index or zero, and pairwise disjoint.
